// File: rtl/p_shfrot_seq.sv
// Multi-cycle packed shift/rotate: one barrel level per cycle, shift amount LSB-first,
// early exit once no higher shift-amount bits remain, result held until accepted.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RUN   | applying barrel level k to the data register
// DONE  | response presented, held until rsp_ready
module p_shfrot_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_crs1,
  input  logic [4:0]  req_shamt,
  input  logic [4:0]  req_pw,
  input  logic        req_shift,
  input  logic        req_rotate,
  input  logic        req_left,
  input  logic        req_right,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_error
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] data, data_nxt;
  logic        error, error_nxt;
  logic [2:0]  k, k_nxt;
  logic [4:0]  shamt, shamt_nxt;
  logic [4:0]  pw, pw_nxt;
  logic        rot, rot_nxt;
  logic        left, left_nxt;

  logic        illegal;
  logic        last_level;
  logic [4:0]  shamt_hi;
  logic [2:0]  lw;
  logic [31:0] rep;
  logic [5:0]  s_amt, w_amt, inv_amt;
  logic [31:0] low, m_lo, m_hi, stepped;

  assign req_ready  = (state == IDLE) && g_resetn;
  assign rsp_valid  = (state == DONE);
  assign rsp_result = data;
  assign rsp_error  = error;

  assign illegal = (req_pw == 5'd0) || ((req_pw & (req_pw - 5'd1)) != 5'd0) ||
                   (req_shift == req_rotate) || (req_left == req_right);

  assign shamt_hi   = shamt >> (k + 3'd1);
  assign last_level = (k == 3'd4) || (shamt_hi == 5'd0);

  // Lane geometry: lw = log2(lane width); rep has a 1 at the bottom bit of every lane.
  always_comb begin
    lw  = 3'd5;
    rep = 32'h0000_0001;
    case (pw)
      5'b00001: begin lw = 3'd5; rep = 32'h0000_0001; end
      5'b00010: begin lw = 3'd4; rep = 32'h0001_0001; end
      5'b00100: begin lw = 3'd3; rep = 32'h0101_0101; end
      5'b01000: begin lw = 3'd2; rep = 32'h1111_1111; end
      5'b10000: begin lw = 3'd1; rep = 32'h5555_5555; end
      default:  begin lw = 3'd5; rep = 32'h0000_0001; end
    endcase
  end

  // m_lo marks the low s bits of each lane, m_hi the high s bits; the product cannot
  // carry across lanes because s is strictly smaller than the lane width when used.
  always_comb begin
    s_amt   = 6'd1 << k;
    w_amt   = 6'd1 << lw;
    inv_amt = w_amt - s_amt;
    low     = (32'd1 << s_amt) - 32'd1;
    m_lo    = rep * low;
    m_hi    = m_lo << inv_amt;
    if (k >= lw)
      stepped = rot ? data : 32'd0;
    else if (left)
      stepped = ((data << s_amt) & ~m_lo) | (rot ? ((data >> inv_amt) & m_lo) : 32'd0);
    else
      stepped = ((data >> s_amt) & ~m_hi) | (rot ? ((data << inv_amt) & m_hi) : 32'd0);
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    error_nxt = error;
    k_nxt     = k;
    shamt_nxt = shamt;
    pw_nxt    = pw;
    rot_nxt   = rot;
    left_nxt  = left;
    case (state)
      IDLE: begin
        if (req_valid) begin
          shamt_nxt = req_shamt;
          pw_nxt    = req_pw;
          rot_nxt   = req_rotate;
          left_nxt  = req_left;
          k_nxt     = 3'd0;
          if (illegal) begin
            state_nxt = DONE;
            error_nxt = 1'b1;
            data_nxt  = 32'd0;
          end else begin
            state_nxt = RUN;
            error_nxt = 1'b0;
            data_nxt  = req_crs1;
          end
        end
      end
      RUN: begin
        if (shamt[k])
          data_nxt = stepped;
        if (last_level)
          state_nxt = DONE;
        else
          k_nxt = k + 3'd1;
      end
      DONE: begin
        if (rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush)
      state_nxt = IDLE;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state <= IDLE;
      data  <= 32'd0;
      error <= 1'b0;
      k     <= 3'd0;
      shamt <= 5'd0;
      pw    <= 5'b00001;
      rot   <= 1'b0;
      left  <= 1'b0;
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
      error <= error_nxt;
      k     <= k_nxt;
      shamt <= shamt_nxt;
      pw    <= pw_nxt;
      rot   <= rot_nxt;
      left  <= left_nxt;
    end
  end

endmodule

// File: tb/tb_p_shfrot_seq.sv
// Directed bench for p_shfrot_seq: hand-computed packed shift/rotate results,
// response latency, handshake hold, flush and mid-run reset.
module tb_p_shfrot_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_crs1;
  logic [4:0]  req_shamt;
  logic [4:0]  req_pw;
  logic        req_shift, req_rotate, req_left, req_right;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_error;

  int checks = 0;
  int failures = 0;

  p_shfrot_seq dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_crs1(req_crs1),
    .req_shamt(req_shamt), .req_pw(req_pw), .req_shift(req_shift),
    .req_rotate(req_rotate), .req_left(req_left), .req_right(req_right),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error)
  );

  always #5 g_clk = ~g_clk;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // Presents one request for a single cycle, then counts cycles until rsp_valid.
  // lat = number of cycles after the accept cycle T at which rsp_valid is seen.
  task automatic send(input logic [31:0] crs1, input logic [4:0] shamt, input logic [4:0] pw,
                      input logic sh, input logic ro, input logic le, input logic ri,
                      output int lat);
    req_valid = 1'b1; req_crs1 = crs1; req_shamt = shamt; req_pw = pw;
    req_shift = sh; req_rotate = ro; req_left = le; req_right = ri;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_error !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b result=%h error=%b ready=%b, want 0 0 0 0",
               rsp_valid, rsp_result, rsp_error, req_ready);
    end
    g_resetn = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_op(input string name, input logic [31:0] crs1, input logic [4:0] shamt,
                         input logic [4:0] pw, input logic sh, input logic ro, input logic le,
                         input logic ri, input logic [31:0] exp_res, input logic exp_err,
                         input int exp_lat);
    int lat;
    send(crs1, shamt, pw, sh, ro, le, ri, lat);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got T+%0d want T+%0d", name, lat, exp_lat);
    end
    checks++;
    if (rsp_result !== exp_res || rsp_error !== exp_err) begin
      failures++;
      $display("FAIL %s_result: got %h err=%b want %h err=%b", name, rsp_result, rsp_error,
               exp_res, exp_err);
    end
    accept();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_release: valid=%b ready=%b want 0 1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_hold();
    int lat;
    send(32'h8001_0203, 5'd1, 5'b00100, 1'b0, 1'b1, 1'b1, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h0102_0406 || rsp_error !== 1'b0 ||
          req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: valid=%b result=%h err=%b ready=%b want 1 01020406 0 0",
                 i, rsp_valid, rsp_result, rsp_error, req_ready);
      end
    end
    accept();
  endtask

  task automatic test_flush();
    int seen = 0;
    req_valid = 1'b1; req_crs1 = 32'hFFFF_FFFF; req_shamt = 5'd31; req_pw = 5'b00001;
    req_shift = 1'b1; req_rotate = 1'b0; req_left = 1'b0; req_right = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL flush_no_rsp: rsp_valid seen %0d cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid_run();
    req_valid = 1'b1; req_crs1 = 32'hFFFF_FFFF; req_shamt = 5'd16; req_pw = 5'b00001;
    req_shift = 1'b1; req_rotate = 1'b0; req_left = 1'b1; req_right = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (rsp_result !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL midrun_data: got %h want ffffffff", rsp_result);
    end
    g_resetn = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_error !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: valid=%b result=%h err=%b ready=%b want 0 0 0 0",
               rsp_valid, rsp_result, rsp_error, req_ready);
    end
    g_resetn = 1'b1;
    tick();
  endtask

  initial begin
    g_resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_crs1 = '0; req_shamt = '0; req_pw = 5'b00001;
    req_shift = 1'b1; req_rotate = 1'b0; req_left = 1'b1; req_right = 1'b0;

    test_reset();
    test_op("rotl_w8",     32'h8001_0203, 5'd1,  5'b00100, 0, 1, 1, 0, 32'h0102_0406, 0, 2);
    test_op("shr_w32_31",  32'hFFFF_FFFF, 5'd31, 5'b00001, 1, 0, 0, 1, 32'h0000_0001, 0, 6);
    test_op("shr_w32_0",   32'hFFFF_FFFF, 5'd0,  5'b00001, 1, 0, 0, 1, 32'hFFFF_FFFF, 0, 2);
    test_op("rotl_w16",    32'h1234_5678, 5'd4,  5'b00010, 0, 1, 1, 0, 32'h2341_6785, 0, 4);
    test_op("shl_w2",      32'hFFFF_FFFF, 5'd2,  5'b10000, 1, 0, 1, 0, 32'h0000_0000, 0, 3);
    test_op("rotl_w2",     32'h0000_0009, 5'd3,  5'b10000, 0, 1, 1, 0, 32'h0000_0006, 0, 3);
    test_op("shr_w8",      32'hF0F0_F0F0, 5'd2,  5'b00100, 1, 0, 0, 1, 32'h3C3C_3C3C, 0, 3);
    test_op("illegal_pw",  32'h1234_5678, 5'd3,  5'b00011, 1, 0, 1, 0, 32'h0000_0000, 1, 1);
    test_op("illegal_dir", 32'h1234_5678, 5'd3,  5'b00001, 1, 0, 1, 1, 32'h0000_0000, 1, 1);
    test_hold();
    test_flush();
    test_op("rotr_w4_after_flush", 32'h1234_5678, 5'd1, 5'b01000, 0, 1, 0, 1, 32'h8192_A3B4, 0, 2);
    test_reset_mid_run();
    test_op("back_to_back", 32'h1234_5678, 5'd4, 5'b00010, 0, 1, 1, 0, 32'h2341_6785, 0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p_shfrot_seq.md
# p_shfrot_seq

Multi-cycle sequencer for the packed shift/rotate operation, serving the execute stage when the single-cycle barrel shifter is too costly in area or timing. It accepts one request over a valid/ready handshake and applies one barrel level per cycle, processing the shift amount LSB-first in a single shared level-step datapath. It ends early once no higher shift-amount bits remain, and holds the result until the consumer accepts it.

## Interface
Parameters: none (datapath fixed at 32 bits, 5 barrel levels).

Ports:
- g_clk  in  1  clock; all state on rising edge
- g_resetn  in  1  reset, synchronous, active-low
- flush  in  1  abandon any in-flight operation; no response produced
- req_valid  in  1  request present
- req_ready  out  1  = (state==IDLE) && g_resetn
- req_crs1  in  32  source operand
- req_shamt  in  5  shift amount
- req_pw  in  5  one-hot pack width: [0]=32, [1]=16, [2]=8, [3]=4, [4]=2
- req_shift, req_rotate  in  1 each  operation class, exactly one set
- req_left, req_right  in  1 each  direction, exactly one set
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  packed result
- rsp_error  out  1  request had illegal controls

## Operation
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch crs1 into data reg, plus shamt, pw, rotate, left. Clear level counter k=0.
  - Legal controls: go to RUN.
  - Illegal controls (pw not one-hot, shift==rotate, or left==right): go to DONE with error=1, data=0.
- RUN, each cycle at level k:
  - If shamt[k]=1, shift/rotate every lane of width W by 2^k in the latched direction; otherwise data is unchanged.
  - If 2^k >= W: a shift zeroes every lane; a rotate leaves data unchanged. Net effect: shift by shamt >= W gives 0, rotate uses shamt mod W.
  - Shift fills vacated bits with 0. Rotate wraps bits within the lane only; bits never cross lane boundaries.
  - After processing level k: if k==4 or shamt[4:k+1]==0, go to DONE; else k<=k+1.
- DONE: rsp_valid=1, rsp_result=data, rsp_error=error.
  - Outputs stay stable while rsp_ready=0.
  - On rsp_ready, go to IDLE. A new request is accepted no earlier than the following cycle (no bypass).
- flush (any state): go to IDLE next edge and drop the response. flush has priority over both handshakes in the same cycle.
- Reset (g_resetn=0 at an edge, any state): state=IDLE, data=0, error=0, k=0.

## Timing
- Reset values: rsp_valid=0, rsp_result=0, rsp_error=0. req_ready=0 while g_resetn=0, and 1 from the first cycle after reset release.
- Request accepted in cycle T. RUN occupies cycles T+1..T+n, where n = (index of highest set bit of shamt)+1, minimum 1 (shamt=0 gives n=1). rsp_valid rises in cycle T+n+1.
- Illegal request: rsp_valid in cycle T+1, no RUN cycles.
- Throughput: at most one request per n+2 cycles when rsp_ready is held high.
- All outputs are registered except req_ready, which is decoded from state.

## Test plan
- Rotate-left, pw=5'b00100, crs1=0x80010203, shamt=1 -> rsp_result=0x01020406, rsp_error=0, rsp_valid in T+2.
- Shift-right, pw=5'b00001, crs1=0xFFFFFFFF, shamt=31 -> 0x00000001, rsp_valid in T+6. Repeat with shamt=0 -> 0xFFFFFFFF, rsp_valid in T+2.
- Rotate-left, pw=5'b00010, crs1=0x12345678, shamt=4 -> 0x23416785, rsp_valid in T+4.
- Width 2, pw=5'b10000, crs1=0xFFFFFFFF:
  - shift-left, shamt=2 -> 0x00000000.
  - rotate-left, crs1=0x00000009, shamt=3 -> 0x00000006.
- Illegal pw=5'b00011 -> rsp_error=1, rsp_result=0, rsp_valid in T+1. Also check both left and right set -> same error response.
- Hold rsp_ready=0 for 3 cycles in DONE -> outputs stable and req_ready=0. Then:
  - flush during RUN -> IDLE next cycle and no rsp_valid.
  - g_resetn=0 mid-RUN -> all outputs reset next edge.
  - A new request after flush completes correctly.
